preg_ready_table: RTL and testbench
===================================

// Module: preg_ready_table
// PURPOSE
//  Physical-register ready (busy) table; answers the issue stage's per-slot source-readiness query
//  (ready.v1/v2) for each renamed bundle. Tracks one ready bit per physical register: cleared when
//  rename allocates a destination, set when an execute-side wakeup broadcasts that preg.
//  Sits between rename/wakeup producers and the issue-queue write path.
// PARAMETERS
//  PREG_NUM     64  number of physical registers; preg 0 hardwired ready
//  FETCH_WIDTH  4   bundle width (query and allocation slots)
//  WAKE_WIDTH   4   wakeup broadcast ports per cycle
// PORTS (PID_W = $clog2(PREG_NUM))
//  clk          in   1                        clock
//  reset        in   1                        asynchronous, active-high reset
//  alloc_en     in   1                        bundle accepted by issue (issue queues not full)
//  alloc_valid  in   FETCH_WIDTH              slot i allocates a destination preg
//  alloc_pid    in   FETCH_WIDTH*PID_W        destination preg of slot i
//  q1_valid     in   FETCH_WIDTH              slot i src1 is renamed (psrc1.valid)
//  q1_pid       in   FETCH_WIDTH*PID_W        slot i src1 preg
//  q2_valid     in   FETCH_WIDTH              slot i src2 is renamed
//  q2_pid       in   FETCH_WIDTH*PID_W        slot i src2 preg
//  v1           out  FETCH_WIDTH              slot i src1 ready
//  v2           out  FETCH_WIDTH              slot i src2 ready
//  wake_valid   in   WAKE_WIDTH               wakeup port k valid
//  wake_pid     in   WAKE_WIDTH*PID_W         preg produced by port k
//  flush        in   1                        pipeline flush (mispredict/exception)
//  busy_cnt     out  PID_W+1                  registered count of not-ready pregs
// BEHAVIOUR
//  - State: rdy[PREG_NUM-1:0]. Reset (async): rdy = all ones; busy_cnt = 0. v1/v2 comb, no reset value.
//  - Query (0-cycle, combinational): v1[i] = !q1_valid[i] | q1_pid[i]==0 |
//      ((rdy[q1_pid[i]] | any_k(wake_valid[k] & wake_pid[k]==q1_pid[i])) & !intra1[i]); v2 alike.
//  - Intra-bundle dependency: intra1[i] = any j<i with alloc_valid[j] & alloc_pid[j]==q1_pid[i]
//      & alloc_pid[j]!=0; such sources are never ready, even if woken this cycle (wake refers to the
//      old producer). Slot i's own alloc_pid does not affect slot i's queries.
//  - Update at posedge, when flush=0:
//      set rdy[wake_pid[k]] for each valid k; then, if alloc_en, clear rdy[alloc_pid[i]] for each
//      alloc_valid[i] with pid!=0. Alloc wins over wake on the same pid in the same cycle.
//      alloc_en=0: allocations ignored, wakeups still applied.
//  - flush=1: next rdy = all ones (all in-flight producers squashed; committed state ready);
//      alloc and wake ignored that cycle; busy_cnt -> 0 next cycle.
//  - Duplicate wake_pid across ports: idempotent. Duplicate alloc_pid in one bundle: illegal (rename
//      guarantees uniqueness); assertion in simulation only.
//  - Writes to preg 0 ignored; rdy[0] stays 1 always.
//  - busy_cnt = popcount(~rdy) of the registered next state, updated every cycle (1-cycle latency
//      after the causing edge); range 0..PREG_NUM-1.
//  - Reset asserted mid-operation: table returns to all-ready immediately, no pending updates kept.
// TESTING
//  1 reset; q1_valid=1,q1_pid=5 -> v1=1; busy_cnt=0
//  2 alloc_en=1, slot0 alloc pid 5; next cycle query pid 5 -> v1=0, busy_cnt=1
//  3 pid 5 busy; wake_valid[2]=1,wake_pid=5 same cycle as query 5 -> v1=1 (bypass); next cycle rdy[5]=1
//  4 bundle: slot0 alloc pid 9, slot2 q2_pid=9, wake pid 9 same cycle -> v2[2]=0; after edge rdy[9]=0
//  5 alloc pid 7 and wake pid 7 same edge -> rdy[7]=0; alloc_en=0 with alloc pid 8 -> rdy[8] unchanged
//  6 busy pids 3,4,5 (busy_cnt=3); flush=1 with wake/alloc active -> all ready, busy_cnt=0; alloc pid 0 -> v=1

Source files
------------

// File: rtl/preg_ready_table.sv
// Physical-register ready table: one ready bit per preg, with a combinational source-readiness
// query that bypasses same-cycle wakeups and masks intra-bundle producers.
module preg_ready_table #(
    parameter int unsigned PREG_NUM    = 64,
    parameter int unsigned FETCH_WIDTH = 4,
    parameter int unsigned WAKE_WIDTH  = 4,
    localparam int unsigned PID_W      = $clog2(PREG_NUM)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           alloc_en,
    input  logic [FETCH_WIDTH-1:0]         alloc_valid,
    input  logic [FETCH_WIDTH*PID_W-1:0]   alloc_pid,
    input  logic [FETCH_WIDTH-1:0]         q1_valid,
    input  logic [FETCH_WIDTH*PID_W-1:0]   q1_pid,
    input  logic [FETCH_WIDTH-1:0]         q2_valid,
    input  logic [FETCH_WIDTH*PID_W-1:0]   q2_pid,
    output logic [FETCH_WIDTH-1:0]         v1,
    output logic [FETCH_WIDTH-1:0]         v2,
    input  logic [WAKE_WIDTH-1:0]          wake_valid,
    input  logic [WAKE_WIDTH*PID_W-1:0]    wake_pid,
    input  logic                           flush,
    output logic [PID_W:0]                 busy_cnt
);

    logic [PREG_NUM-1:0] rdy_q, rdy_d;
    logic [PID_W:0]      busy_cnt_q, busy_cnt_d;
    logic                dup_alloc;

    // An earlier slot allocating this preg means the source names the new producer, so a wakeup
    // seen this cycle belongs to the old one and must not make it ready.
    function automatic logic src_ready(input logic vld, input logic [PID_W-1:0] pid,
                                       input int slot);
        logic hit;
        logic intra;
        hit   = rdy_q[pid];
        intra = 1'b0;
        for (int k = 0; k < WAKE_WIDTH; k++) begin
            if (wake_valid[k] && wake_pid[k*PID_W +: PID_W] == pid) hit = 1'b1;
        end
        for (int j = 0; j < FETCH_WIDTH; j++) begin
            if (j < slot && alloc_valid[j] && alloc_pid[j*PID_W +: PID_W] == pid &&
                pid != '0) intra = 1'b1;
        end
        return !vld || pid == '0 || (hit && !intra);
    endfunction

    always_comb begin
        v1 = '0;
        v2 = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            v1[i] = src_ready(q1_valid[i], q1_pid[i*PID_W +: PID_W], i);
            v2[i] = src_ready(q2_valid[i], q2_pid[i*PID_W +: PID_W], i);
        end
    end

    always_comb begin
        rdy_d = rdy_q;
        if (flush) begin
            rdy_d = '1;
        end else begin
            for (int k = 0; k < WAKE_WIDTH; k++) begin
                if (wake_valid[k]) rdy_d[wake_pid[k*PID_W +: PID_W]] = 1'b1;
            end
            // Applied after wakeups so allocation wins on a shared pid.
            if (alloc_en) begin
                for (int i = 0; i < FETCH_WIDTH; i++) begin
                    if (alloc_valid[i]) rdy_d[alloc_pid[i*PID_W +: PID_W]] = 1'b0;
                end
            end
        end
        rdy_d[0] = 1'b1;

        busy_cnt_d = '0;
        for (int p = 0; p < PREG_NUM; p++) begin
            busy_cnt_d = busy_cnt_d + {{PID_W{1'b0}}, ~rdy_d[p]};
        end
    end

    always_comb begin
        dup_alloc = 1'b0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            for (int j = 0; j < FETCH_WIDTH; j++) begin
                if (i < j && alloc_valid[i] && alloc_valid[j] &&
                    alloc_pid[i*PID_W +: PID_W] == alloc_pid[j*PID_W +: PID_W] &&
                    alloc_pid[i*PID_W +: PID_W] != '0) dup_alloc = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_q      <= '1;
            busy_cnt_q <= '0;
        end else begin
            rdy_q      <= rdy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    a_unique_alloc: assert property (@(posedge clk) disable iff (reset)
        !(alloc_en && !flush && dup_alloc));

endmodule

// File: tb/tb_preg_ready_table.sv
// Randomized bench for preg_ready_table against a set-based readiness model, plus directed cases.
module tb_preg_ready_table;

    localparam int PN = 64;
    localparam int FW = 4;
    localparam int WW = 4;
    localparam int PW = 6;

    logic              clk, reset, alloc_en, flush;
    logic [FW-1:0]     alloc_valid, q1_valid, q2_valid, v1, v2;
    logic [FW*PW-1:0]  alloc_pid, q1_pid, q2_pid;
    logic [WW-1:0]     wake_valid;
    logic [WW*PW-1:0]  wake_pid;
    logic [PW:0]       busy_cnt;

    preg_ready_table #(.PREG_NUM(PN), .FETCH_WIDTH(FW), .WAKE_WIDTH(WW)) dut (
        .clk(clk), .reset(reset), .alloc_en(alloc_en), .alloc_valid(alloc_valid),
        .alloc_pid(alloc_pid), .q1_valid(q1_valid), .q1_pid(q1_pid), .q2_valid(q2_valid),
        .q2_pid(q2_pid), .v1(v1), .v2(v2), .wake_valid(wake_valid), .wake_pid(wake_pid),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;
    bit  m_ready [PN];   // model: which pregs hold a produced value

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int apid(input int s);  return int'(alloc_pid[s*PW +: PW]); endfunction
    function automatic int wpid(input int k);  return int'(wake_pid[k*PW +: PW]);  endfunction

    function automatic bit model_src(input int slot, input bit vld, input int pid);
        if (!vld || pid == 0) return 1'b1;
        for (int j = 0; j < slot; j++)
            if (alloc_valid[j] && apid(j) == pid) return 1'b0;
        if (m_ready[pid]) return 1'b1;
        for (int k = 0; k < WW; k++)
            if (wake_valid[k] && wpid(k) == pid) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_busy();
        int n = 0;
        for (int p = 0; p < PN; p++) if (!m_ready[p]) n++;
        return n;
    endfunction

    task automatic clear_inputs();
        alloc_en = 0; flush = 0; alloc_valid = '0; alloc_pid = '0; q1_valid = '0; q1_pid = '0;
        q2_valid = '0; q2_pid = '0; wake_valid = '0; wake_pid = '0;
    endtask

    task automatic set_alloc(input int s, input int pid);
        alloc_valid[s] = 1'b1; alloc_pid[s*PW +: PW] = PW'(pid);
    endtask
    task automatic set_q1(input int s, input int pid);
        q1_valid[s] = 1'b1; q1_pid[s*PW +: PW] = PW'(pid);
    endtask
    task automatic set_q2(input int s, input int pid);
        q2_valid[s] = 1'b1; q2_pid[s*PW +: PW] = PW'(pid);
    endtask
    task automatic set_wake(input int k, input int pid);
        wake_valid[k] = 1'b1; wake_pid[k*PW +: PW] = PW'(pid);
    endtask

    task automatic check_comb();
        for (int i = 0; i < FW; i++) begin
            chk($sformatf("v1[%0d]", i), int'(v1[i]), int'(model_src(i, q1_valid[i], int'(q1_pid[i*PW +: PW]))));
            chk($sformatf("v2[%0d]", i), int'(v2[i]), int'(model_src(i, q2_valid[i], int'(q2_pid[i*PW +: PW]))));
        end
    endtask

    // Compare the query, advance one clock, then apply the update rules to the model.
    task automatic step();
        bit nxt [PN];
        #1;
        check_comb();
        nxt = m_ready;
        if (flush) begin
            for (int p = 0; p < PN; p++) nxt[p] = 1'b1;
        end else begin
            for (int k = 0; k < WW; k++) if (wake_valid[k]) nxt[wpid(k)] = 1'b1;
            if (alloc_en)
                for (int s = 0; s < FW; s++)
                    if (alloc_valid[s] && apid(s) != 0) nxt[apid(s)] = 1'b0;
        end
        @(posedge clk);
        #1;
        m_ready = nxt;
        chk("busy_cnt", int'(busy_cnt), model_busy());
    endtask

    function automatic int rand_pid(input bit narrow);
        return narrow ? int'($urandom_range(0, 15)) : int'($urandom_range(0, PN-1));
    endfunction

    task automatic randomize_inputs();
        bit narrow;
        int p;
        bit clash;
        clear_inputs();
        narrow   = ($urandom_range(0, 3) != 0);
        alloc_en = ($urandom_range(0, 3) != 0);
        flush    = ($urandom_range(0, 31) == 0);
        for (int s = 0; s < FW; s++) begin
            if ($urandom_range(0, 1) == 1) begin
                p = 0;
                for (int t = 0; t < 20; t++) begin
                    p = rand_pid(narrow);
                    clash = 1'b0;
                    for (int j = 0; j < s; j++)
                        if (alloc_valid[j] && apid(j) == p && p != 0) clash = 1'b1;
                    if (!clash) break;
                    p = 0;
                end
                set_alloc(s, p);
            end
            if ($urandom_range(0, 3) != 0) set_q1(s, rand_pid(narrow));
            if ($urandom_range(0, 3) != 0) set_q2(s, rand_pid(narrow));
        end
        for (int k = 0; k < WW; k++)
            if ($urandom_range(0, 2) == 0) set_wake(k, rand_pid(narrow));
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        for (int p = 0; p < PN; p++) m_ready[p] = 1'b1;
        #12;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset state: everything ready, nothing busy.
        set_q1(0, 5);
        #1;
        chk("rst_v1", int'(v1[0]), 1);
        chk("rst_busy", int'(busy_cnt), 0);
        clear_inputs();

        // Allocate pid 5, then it reads busy.
        alloc_en = 1; set_alloc(0, 5);
        step();
        clear_inputs(); set_q1(0, 5);
        #1;
        chk("alloc5_v1", int'(v1[0]), 0);
        chk("alloc5_busy", int'(busy_cnt), 1);

        // Same-cycle wakeup bypasses into the query and then sticks.
        set_wake(2, 5);
        #1;
        chk("bypass5_v1", int'(v1[0]), 1);
        step();
        clear_inputs(); set_q1(0, 5);
        #1;
        chk("woken5_v1", int'(v1[0]), 1);
        chk("woken5_busy", int'(busy_cnt), 0);

        // Intra-bundle producer masks even a same-cycle wakeup.
        clear_inputs();
        alloc_en = 1; set_alloc(0, 9); set_q2(2, 9); set_wake(0, 9);
        #1;
        chk("intra9_v2", int'(v2[2]), 0);
        step();
        clear_inputs(); set_q2(2, 9);
        #1;
        chk("after9_v2", int'(v2[2]), 0);
        chk("after9_busy", int'(busy_cnt), 1);

        // Alloc beats wake on the same pid; alloc_en=0 ignores allocation.
        clear_inputs();
        alloc_en = 1; set_alloc(1, 7); set_wake(3, 7);
        step();
        clear_inputs(); set_q1(3, 7);
        #1;
        chk("alloc_wins7", int'(v1[3]), 0);
        clear_inputs();
        set_alloc(0, 8);
        step();
        clear_inputs(); set_q1(1, 8);
        #1;
        chk("noen8_v1", int'(v1[1]), 1);
        chk("noen8_busy", int'(busy_cnt), 2);

        // Flush clears everything even with alloc/wake active.
        clear_inputs(); flush = 1;
        step();
        clear_inputs();
        alloc_en = 1; set_alloc(0, 3); set_alloc(1, 4); set_alloc(2, 5);
        step();
        chk("busy345", int'(busy_cnt), 3);
        clear_inputs();
        flush = 1; alloc_en = 1; set_alloc(0, 10); set_wake(1, 3);
        step();
        chk("flush_busy", int'(busy_cnt), 0);
        clear_inputs(); set_q1(0, 3); set_q2(0, 10);
        #1;
        chk("flush_v1", int'(v1[0]), 1);
        chk("flush_v2", int'(v2[0]), 1);
        clear_inputs();
        alloc_en = 1; set_alloc(0, 0);
        step();
        clear_inputs(); set_q1(2, 0);
        #1;
        chk("pid0_v1", int'(v1[2]), 1);
        chk("pid0_busy", int'(busy_cnt), 0);

        // Randomized traffic, with one asynchronous reset mid-run.
        for (int n = 0; n < 2000; n++) begin
            randomize_inputs();
            if (n == 700) begin
                reset = 1'b1;
                #1;
                for (int p = 0; p < PN; p++) m_ready[p] = 1'b1;
                chk("midrst_busy", int'(busy_cnt), 0);
                check_comb();
                reset = 1'b0;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
